// File: rtl/avr_pcint_pkg.sv
// Shared constants for the PCINT group controllers: register addresses,
// group bit positions and the default pin count of a group.
package avr_pcint_pkg;

   localparam logic [5:0] PCIFR_IO_ADDR_C  = 6'h1B;
   localparam logic [7:0] PCICR_RAM_ADDR_C = 8'h68;
   localparam logic [7:0] PCMSK0_RAM_ADDR  = 8'h6B;
   localparam logic [7:0] PCMSK1_RAM_ADDR  = 8'h6C;
   localparam logic [7:0] PCMSK2_RAM_ADDR  = 8'h6D;
   localparam logic [7:0] PCMSK3_RAM_ADDR  = 8'h73;

   // PCIEn / PCIFn bit positions, one per group
   localparam int GRP0_BIT = 0;
   localparam int GRP1_BIT = 1;
   localparam int GRP2_BIT = 2;
   localparam int GRP3_BIT = 3;

   localparam int PCINT_PIN_WIDTH = 7;

   // which owned register a read cycle selects
   typedef struct packed {
      logic pcifr;
      logic pcicr;
      logic pcmsk;
   } rd_sel_t;

endpackage

// File: rtl/pcint_sync_edge.sv
// Pin input synchroniser, optional glitch filter and history register.
// Produces the per-pin masked change vector for one PCINT group.
// PCINT_GLITCH_FILTER_EN adds a third stage; a level is only accepted
// when two consecutive synchronised samples agree.
module pcint_sync_edge #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] pin_i,
   input  logic [W-1:0] mask,
   output logic [W-1:0] chg
);

   logic [W-1:0] sync1, sync2, prev, level;

   // two-flop synchroniser; prev always tracks the accepted level, even for
   // masked pins, so enabling a mask bit never sees stale history
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= pin_i;
         sync2 <= sync1;
         prev  <= level;
      end
   end

`ifdef PCINT_GLITCH_FILTER_EN
   logic [W-1:0] sync3;

   // extra stage giving a second sample to compare against
   always_ff @(posedge clk) begin
      if (rst) sync3 <= '0;
      else     sync3 <= sync2;
   end

   // disagreeing samples keep the previous accepted level
   assign level = (sync2 & ~(sync2 ^ sync3)) | (prev & (sync2 ^ sync3));
`else
   assign level = sync2;
`endif

   assign chg = (level ^ prev) & mask;

endmodule

// File: rtl/pcint_group_ctrl.sv
// Pin-change interrupt controller for one PCINT group (default PCINT[14:8]).
// Owns PCMSKn, PCIEn in PCICR and PCIFn in PCIFR; drives the mask and enable
// back to the port and raises the group interrupt request.
// Optional build macro: PCINT_GLITCH_FILTER_EN (rejects 1-cycle pin pulses).
module pcint_group_ctrl
   import avr_pcint_pkg::*;
#(
   parameter int             PIN_WIDTH      = PCINT_PIN_WIDTH,
   parameter int             GRP_BIT        = GRP1_BIT,
   parameter logic [5:0]     PCIFR_IO_ADDR  = PCIFR_IO_ADDR_C,
   parameter logic [7:0]     PCICR_RAM_ADDR = PCICR_RAM_ADDR_C,
   parameter logic [7:0]     PCMSK_RAM_ADDR = PCMSK1_RAM_ADDR
) (
   input  logic                 cp2,
   input  logic                 ireset,
   input  logic [5:0]           IO_Addr,
   input  logic                 iore,
   input  logic                 iowe,
   input  logic [7:0]           ram_Addr,
   input  logic                 ramre,
   input  logic                 ramwe,
   input  logic [7:0]           dbus_in,
   output logic [7:0]           dbus_out,
   output logic                 out_en,
   input  logic [PIN_WIDTH-1:0] pin_i,
   input  logic                 irqack,
   output logic                 irq,
   output logic [PIN_WIDTH-1:0] PCINT,
   output logic                 PCIE
);

   logic [PIN_WIDTH-1:0] mask_q, chg;
   logic                 pcie_q, flag_q;
   logic                 pcifr_we, pcicr_we, pcmsk_we, flag_clr;
   logic [7:0]           mask_ext;
   rd_sel_t              rd_sel;
   logic                 unused_dbus;

   assign pcifr_we = iowe  & (IO_Addr  == PCIFR_IO_ADDR);
   assign pcicr_we = ramwe & (ram_Addr == PCICR_RAM_ADDR);
   assign pcmsk_we = ramwe & (ram_Addr == PCMSK_RAM_ADDR);
   assign flag_clr = (pcifr_we & dbus_in[GRP_BIT]) | irqack;

   // only some data bits are owned here; fold the rest away
   assign unused_dbus = ^dbus_in;

   pcint_sync_edge #(.W(PIN_WIDTH)) u_sync_edge (
      .clk   (cp2),
      .rst   (ireset),
      .pin_i (pin_i),
      .mask  (mask_q),
      .chg   (chg)
   );

   // control registers and the pending flag; a new edge beats a clear
   always_ff @(posedge cp2) begin
      if (ireset) begin
         mask_q <= '0;
         pcie_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         if (pcmsk_we) mask_q <= dbus_in[PIN_WIDTH-1:0];
         if (pcicr_we) pcie_q <= dbus_in[GRP_BIT];
         if (|chg)          flag_q <= 1'b1;
         else if (flag_clr) flag_q <= 1'b0;
      end
   end

   // outputs are forced low while reset is held
   assign irq   = flag_q & pcie_q & ~ireset;
   assign PCINT = ireset ? '0 : mask_q;
   assign PCIE  = pcie_q & ~ireset;

   assign rd_sel.pcifr = ~ireset & iore  & (IO_Addr  == PCIFR_IO_ADDR);
   assign rd_sel.pcicr = ~ireset & ramre & (ram_Addr == PCICR_RAM_ADDR);
   assign rd_sel.pcmsk = ~ireset & ramre & (ram_Addr == PCMSK_RAM_ADDR);
   assign out_en       = |rd_sel;

   // zero-extended mask for the read mux
   always_comb begin
      mask_ext                = '0;
      mask_ext[PIN_WIDTH-1:0] = mask_q;
   end

   // read mux: owned bits only, zeros elsewhere so the top can OR-merge
   always_comb begin
      dbus_out = '0;
      if (rd_sel.pcifr) dbus_out[GRP_BIT] = dbus_out[GRP_BIT] | flag_q;
      if (rd_sel.pcicr) dbus_out[GRP_BIT] = dbus_out[GRP_BIT] | pcie_q;
      if (rd_sel.pcmsk) dbus_out = dbus_out | mask_ext;
   end

endmodule

// File: tb/tb_pcint_group_ctrl.sv
// Self-checking bench for pcint_group_ctrl: directed steps followed by a
// randomized phase, checked against a cycle-level model built from the pin
// history (per-cycle pin array) and the register rules.
module tb_pcint_group_ctrl;

`ifdef PCINT_GLITCH_FILTER_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic       cp2 = 1'b0;
   logic       ireset, iore, iowe, ramre, ramwe, irqack;
   logic [5:0] IO_Addr;
   logic [7:0] ram_Addr, dbus_in, dbus_out;
   logic       out_en, irq, PCIE;
   logic [6:0] pin_i, PCINT;

   pcint_group_ctrl dut (
      .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
      .ram_Addr(ram_Addr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
      .dbus_out(dbus_out), .out_en(out_en), .pin_i(pin_i), .irqack(irqack),
      .irq(irq), .PCINT(PCINT), .PCIE(PCIE)
   );

   always #5 cp2 = ~cp2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rst_cyc  = -1;
   logic [6:0] pinhist [0:4095];
   logic [6:0] m_mask, m_acc;
   logic       m_pcie, m_flag;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // pin level seen in cycle k; anything at or before a reset reads as 0
   function automatic logic [6:0] pv(input int k);
      if (k < 0 || k <= rst_cyc) return 7'h00;
      return pinhist[k];
   endfunction

   // one clock: record pins, advance the model with pre-edge inputs, check
   task automatic tick();
      logic [6:0] a, acc_new, chg;
      pinhist[cyc] = pin_i;
      @(posedge cp2);
      if (ireset) begin
         m_mask = '0; m_pcie = 1'b0; m_flag = 1'b0; m_acc = '0;
         rst_cyc = cyc;
      end else begin
         a = pv(cyc - 2);
`ifdef PCINT_GLITCH_FILTER_EN
         begin
            logic [6:0] b;
            b = pv(cyc - 3);
            for (int i = 0; i < 7; i++)
               acc_new[i] = (a[i] == b[i]) ? a[i] : m_acc[i];
         end
`else
         acc_new = a;
`endif
         chg   = (acc_new ^ m_acc) & m_mask;
         m_acc = acc_new;
         if (chg != 0) m_flag = 1'b1;
         else if ((iowe && IO_Addr == 6'h1B && dbus_in[1]) || irqack) m_flag = 1'b0;
         if (ramwe && ram_Addr == 8'h68) m_pcie = dbus_in[1];
         if (ramwe && ram_Addr == 8'h6C) m_mask = dbus_in[6:0];
      end
      cyc++;
      #1;
      chk("irq",   {7'b0, irq},   {7'b0, m_flag & m_pcie});
      chk("pcint", {1'b0, PCINT}, {1'b0, m_mask});
      chk("pcie",  {7'b0, PCIE},  {7'b0, m_pcie});
   endtask

   task automatic rd(input bit io, input logic [7:0] addr, input logic [7:0] exp, input string tag);
      if (io) begin iore = 1'b1; IO_Addr = addr[5:0]; end
      else    begin ramre = 1'b1; ram_Addr = addr; end
      #1;
      chk({tag, "_oe"}, {7'b0, out_en}, 8'h01);
      chk(tag, dbus_out, exp);
      iore = 1'b0; ramre = 1'b0;
      #1;
      chk({tag, "_idle"}, dbus_out, 8'h00);
   endtask

   task automatic rd_model();
      rd(1'b1, 8'h1B, {6'b0, m_flag, 1'b0}, "m_pcifr");
      rd(1'b0, 8'h68, {6'b0, m_pcie, 1'b0}, "m_pcicr");
      rd(1'b0, 8'h6C, {1'b0, m_mask},       "m_pcmsk");
   endtask

   task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
      ramwe = 1'b1; ram_Addr = a; dbus_in = d;
      tick();
      ramwe = 1'b0;
   endtask

   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      iowe = 1'b1; IO_Addr = a; dbus_in = d;
      tick();
      iowe = 1'b0;
   endtask

   initial begin
      ireset = 1'b1; iore = 1'b0; iowe = 1'b0; ramre = 1'b0; ramwe = 1'b0;
      irqack = 1'b0; IO_Addr = '0; ram_Addr = '0; dbus_in = '0; pin_i = '0;
      #1;
      tick();
      // reads are suppressed while reset is held
      iore = 1'b1; IO_Addr = 6'h1B; ramre = 1'b1; ram_Addr = 8'h6C;
      #1;
      chk("rst_oe",   {7'b0, out_en}, 8'h00);
      chk("rst_dbus", dbus_out,       8'h00);
      iore = 1'b0; ramre = 1'b0;
      tick();
      ireset = 1'b0;
      tick(); tick();
      rd(1'b1, 8'h1B, 8'h00, "rst_pcifr");
      rd(1'b0, 8'h6C, 8'h00, "rst_pcmsk");

      // 1: single masked pin edge -> irq after LAT cycles
      ram_wr(8'h6C, 8'h01);
      ram_wr(8'h68, 8'h02);
      tick(); tick();
      pin_i = 7'h01;
      repeat (LAT - 1) tick();
      chk("t1_irq_early", {7'b0, irq}, 8'h00);
      tick();
      chk("t1_irq", {7'b0, irq}, 8'h01);
      rd(1'b1, 8'h1B, 8'h02, "t1_pcifr");
      rd(1'b0, 8'h68, 8'h02, "t1_pcicr");

      // unowned addresses stay off the bus
      iore = 1'b1; IO_Addr = 6'h1C; ramre = 1'b1; ram_Addr = 8'h6B;
      #1;
      chk("other_oe",   {7'b0, out_en}, 8'h00);
      chk("other_dbus", dbus_out,       8'h00);
      iore = 1'b0; ramre = 1'b0;

      // 2: mask 0 blocks toggles; enabling mask on static pins gives nothing
      io_wr(6'h1B, 8'h02);
      ram_wr(8'h6C, 8'h00);
      for (int i = 0; i < 6; i++) begin pin_i = ~pin_i; tick(); end
      repeat (5) tick();
      rd(1'b1, 8'h1B, 8'h00, "t2_nomask");
      ram_wr(8'h6C, 8'hFF);
      repeat (6) tick();
      rd(1'b1, 8'h1B, 8'h00, "t2_static");
      rd(1'b0, 8'h6C, 8'h7F, "t2_pcmsk");

      // 3: write-1 clears, write-0 keeps
      pin_i ^= 7'h04;
      repeat (LAT + 1) tick();
      rd(1'b1, 8'h1B, 8'h02, "t3_set");
      io_wr(6'h1B, 8'h02);
      rd(1'b1, 8'h1B, 8'h00, "t3_clr");
      pin_i ^= 7'h04;
      repeat (LAT + 1) tick();
      io_wr(6'h1B, 8'hFD);
      rd(1'b1, 8'h1B, 8'h02, "t3_keep");
      io_wr(6'h1B, 8'h02);

      // 4: edge in the same cycle as irqack -> set wins
      pin_i ^= 7'h10;
      repeat (LAT - 1) tick();
      irqack = 1'b1;
      tick();
      irqack = 1'b0;
      chk("t4_irq", {7'b0, irq}, 8'h01);
      rd(1'b1, 8'h1B, 8'h02, "t4_pcifr");
      irqack = 1'b1;
      tick();
      irqack = 1'b0;
      chk("t4_ack", {7'b0, irq}, 8'h00);

      // 5: flag held while disabled, irq on enable
      ram_wr(8'h68, 8'h00);
      pin_i ^= 7'h40;
      repeat (LAT + 1) tick();
      chk("t5_irq_off", {7'b0, irq}, 8'h00);
      rd(1'b1, 8'h1B, 8'h02, "t5_pcifr");
      ram_wr(8'h68, 8'h02);
      chk("t5_irq_on", {7'b0, irq}, 8'h01);
      irqack = 1'b1; tick(); irqack = 1'b0;

      // 6: single-cycle pulse on pin 3
      pin_i ^= 7'h08;
      tick();
      pin_i ^= 7'h08;
`ifdef PCINT_GLITCH_FILTER_EN
      repeat (6) tick();
      rd(1'b1, 8'h1B, 8'h00, "t6_pulse1");
      pin_i ^= 7'h08;
      repeat (3) tick();
      chk("t6_irq_early", {7'b0, irq}, 8'h00);
      pin_i ^= 7'h08;
      tick();
      chk("t6_irq", {7'b0, irq}, 8'h01);
      repeat (6) tick();
`else
      repeat (LAT - 1) tick();
      chk("t6_pulse1", {7'b0, irq}, 8'h01);
      repeat (4) tick();
`endif
      io_wr(6'h1B, 8'h02);

      // reset mid-operation clears flag and history
      pin_i ^= 7'h20;
      repeat (LAT + 1) tick();
      rd(1'b1, 8'h1B, 8'h02, "mr_set");
      ireset = 1'b1;
      tick();
      ireset = 1'b0;
      chk("mr_irq", {7'b0, irq}, 8'h00);
      rd(1'b1, 8'h1B, 8'h00, "mr_pcifr");
      rd(1'b0, 8'h6C, 8'h00, "mr_pcmsk");
      for (int i = 0; i < 4; i++) begin pin_i = 7'($urandom); tick(); end
      repeat (5) tick();
      rd(1'b1, 8'h1B, 8'h00, "mr_nomask");

      // randomized traffic against the model
      ram_wr(8'h68, 8'h02);
      ram_wr(8'h6C, 8'h7F);
      for (int it = 0; it < 500; it++) begin
         int r;
         if ($urandom_range(0, 2) == 0) pin_i = 7'($urandom);
         irqack = ($urandom_range(0, 15) == 0);
         r = $urandom_range(0, 24);
         dbus_in = 8'($urandom);
         case (r)
            0: begin ramwe = 1'b1; ram_Addr = 8'h6C; end
            1: begin ramwe = 1'b1; ram_Addr = 8'h68; end
            2, 3: begin iowe = 1'b1; IO_Addr = 6'h1B; end
            4: begin iowe = 1'b1; IO_Addr = 6'h1C; end
            5: begin ramwe = 1'b1; ram_Addr = 8'h6D; end
            6: if ($urandom_range(0, 7) == 0) ireset = 1'b1;
            default: ;
         endcase
         tick();
         ramwe = 1'b0; iowe = 1'b0; irqack = 1'b0; ireset = 1'b0;
         if (it % 16 == 15) rd_model();
      end
      rd_model();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
